// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: walks the program RAM and steps the 16-bit processor
// one instruction at a time, presenting IW or the mvi immediate on DIN.
module fetch_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int LAST_ADDR = 63,
  parameter int MAX_STEPS = 3
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic              StepMode,
  input  logic [15:0]       MemData,
  input  logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       DIN,
  output logic              ProcEn,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [15:0]       InstrCount
);

  typedef enum logic [3:0] {
    S_IDLE, S_F_INSTR, S_L_INSTR, S_F_IMM, S_L_IMM,
    S_ISSUE, S_EXEC, S_ADVANCE, S_HALT, S_ERROR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);
  localparam logic [1:0]        CNT_MAX = 2'(MAX_STEPS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       iw_q, iw_d;
  logic [15:0]       imm_q, imm_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       count_q, count_d;
  logic              prev_run_q;
  logic [15:0]       din_q, din_d;
  logic              proc_en_q, busy_q, halted_q, err_q;

  function automatic logic is_mvi(input logic [15:0] w);
    return w[8:6] == 3'b001;
  endfunction

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iw_d    = iw_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (Run && (!StepMode || !prev_run_q)) state_d = S_F_INSTR;
      end
      S_F_INSTR: state_d = S_L_INSTR;
      S_L_INSTR: begin
        iw_d = MemData;
        if (is_mvi(MemData)) begin
          if (pc_q == LAST_PC) begin
            state_d = S_ERROR;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_F_IMM;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_F_IMM: state_d = S_L_IMM;
      S_L_IMM: begin
        imm_d   = MemData;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = 2'd0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (Done)                  state_d = S_ADVANCE;
        else if (cnt_q == CNT_MAX) state_d = S_ERROR;
        else                       cnt_d   = cnt_q + 2'd1;
      end
      S_ADVANCE: begin
        count_d = count_q + 16'd1;
        if (pc_q == LAST_PC) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (StepMode || !Run) ? S_IDLE : S_F_INSTR;
        end
      end
      default: state_d = state_q;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    case (state_d)
      S_ISSUE: din_d = iw_d;
      S_EXEC:  din_d = is_mvi(iw_d) ? imm_d : iw_d;
      default: din_d = 16'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      iw_q       <= 16'd0;
      imm_q      <= 16'd0;
      cnt_q      <= 2'd0;
      count_q    <= 16'd0;
      prev_run_q <= 1'b0;
      din_q      <= 16'd0;
      proc_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iw_q       <= iw_d;
      imm_q      <= imm_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      prev_run_q <= Run;
      din_q      <= din_d;
      proc_en_q  <= (state_d == S_ISSUE) || (state_d == S_EXEC);
      busy_q     <= !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_ERROR));
      halted_q   <= (state_d == S_HALT) || (state_d == S_ERROR);
      err_q      <= (state_d == S_ERROR);
    end
  end

  assign MemAddr    = pc_q;
  assign DIN        = din_q;
  assign ProcEn     = proc_en_q;
  assign Busy       = busy_q;
  assign Halted     = halted_q;
  assign Err        = err_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: synchronous RAM and processor step model around the
// sequencer, with a program-level reference model for timing and DIN traffic.
module tb_fetch_sequencer;
  localparam int AW   = 6;
  localparam int LAST = 3;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, run, step_mode, done, kill;
  logic [15:0]   mem_data, din, instr_count;
  logic [AW-1:0] mem_addr;
  logic          proc_en, busy, halted, err;
  logic [15:0]   mem [64];

  fetch_sequencer #(.ADDR_W(AW), .LAST_ADDR(LAST), .MAX_STEPS(MAXS)) dut (
    .Clock(clk), .Resetn(rst), .Run(run), .StepMode(step_mode),
    .MemData(mem_data), .Done(done), .MemAddr(mem_addr), .DIN(din),
    .ProcEn(proc_en), .Busy(busy), .Halted(halted), .Err(err),
    .InstrCount(instr_count)
  );

  always @(posedge clk) mem_data <= mem[mem_addr];

  // Processor: step 0 loads IR from DIN; mv/mvi take 2 steps, others 4.
  function automatic int steps_of(input logic [15:0] w);
    return (w[8:7] == 2'b00) ? 2 : 4;
  endfunction

  logic [2:0]  stp;
  logic [15:0] ir;
  assign done = proc_en && !kill && (stp != 3'd0) && (int'(stp) == steps_of(ir) - 1);
  always @(posedge clk) begin
    if (rst) stp <= 3'd0;
    else if (proc_en) begin
      if (stp == 3'd0) ir <= din;
      stp <= done ? 3'd0 : stp + 3'd1;
    end
  end

  logic [15:0] din_q [$];
  int pe_cnt;
  always @(negedge clk) if (proc_en) begin
    din_q.push_back(din);
    pe_cnt++;
  end

  int n_chk = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: free-running execution of the whole program.
  logic [15:0] exp_q [$];
  int m_count, m_pc, m_cycles;
  bit m_err;
  task automatic model();
    int pc;
    logic [15:0] w;
    exp_q.delete();
    pc = 0; m_count = 0; m_cycles = 1; m_err = 0;
    while (1) begin
      w = mem[pc];
      if (w[8:6] == 3'b001) begin
        if (pc == LAST) begin m_err = 1; m_cycles += 2; break; end
        exp_q.push_back(w); exp_q.push_back(mem[pc+1]);
        pc++; m_cycles += 7;
      end else if (w[8:6] == 3'b000) begin
        exp_q.push_back(w); exp_q.push_back(w); m_cycles += 5;
      end else begin
        repeat (4) exp_q.push_back(w); m_cycles += 7;
      end
      m_count++;
      if (pc == LAST) break;
      pc++;
    end
    m_pc = pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    din_q.delete(); pe_cnt = 0;
  endtask

  task automatic go_free(input string tag);
    int c;
    model();
    step_mode = 1'b0; run = 1'b1;
    c = 0;
    while (!halted && c < 300) begin
      @(posedge clk); c++;
      @(negedge clk);
    end
    check({tag, ".halted"}, halted, 1);
    check({tag, ".cycles"}, c, m_cycles);
    check({tag, ".err"}, err, m_err);
    check({tag, ".count"}, instr_count, m_count);
    check({tag, ".pe_cnt"}, pe_cnt, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s.din%0d", tag, i), (i < din_q.size()) ? din_q[i] : 16'hxxxx, exp_q[i]);
    repeat (3) @(negedge clk);
    check({tag, ".pc_hold"}, mem_addr, m_pc);
    check({tag, ".pe_off"}, proc_en, 0);
    check({tag, ".busy_off"}, busy, 0);
    run = 1'b0;
  endtask

  task automatic run_free(input string tag);
    do_reset();
    go_free(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".addr"}, mem_addr, 0);
    check({tag, ".din"}, din, 0);
    check({tag, ".pe"}, proc_en, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".halted"}, halted, 0);
    check({tag, ".err"}, err, 0);
    check({tag, ".count"}, instr_count, 0);
  endtask

  logic [15:0] w;
  int c;
  logic [AW-1:0] trace [4];

  initial begin
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; kill = 1'b0; pe_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

    do_reset();
    check_reset_vals("rst0");

    // Four mv words: program end at LAST.
    for (int i = 0; i < 4; i++) mem[i] = 16'h0008;
    run_free("mv4");

    // mvi at LAST_ADDR raises Err without issuing it.
    mem[3] = 16'h0040;
    run_free("mvi_last");

    // Step mode with an mvi first.
    mem[0] = 16'h0040; mem[1] = 16'h00A5; mem[2] = 16'h0008; mem[3] = 16'h0008;
    do_reset();
    step_mode = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); trace[i] = mem_addr;
    end
    check("step.addr0", trace[0], 0);
    check("step.addr1", trace[1], 0);
    check("step.addr2", trace[2], 1);
    check("step.addr3", trace[3], 1);
    c = 0;
    while (busy && c < 50) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    check("step.count1", instr_count, 1);
    check("step.pc2", mem_addr, 2);
    check("step.din_n", din_q.size(), 2);
    check("step.din_issue", din_q.size() > 0 ? din_q[0] : 16'hxxxx, 16'h0040);
    check("step.din_exec", din_q.size() > 1 ? din_q[1] : 16'hxxxx, 16'h00A5);
    run = 1'b0; @(negedge clk); run = 1'b1;
    @(negedge clk);
    c = 0;
    while (busy && c < 50) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    check("step.count2", instr_count, 2);
    check("step.pc3", mem_addr, 3);
    step_mode = 1'b0; run = 1'b0;

    // Watchdog: Done never comes.
    mem[0] = 16'h0080;
    do_reset();
    kill = 1'b1; run = 1'b1;
    c = 0;
    while (!halted && c < 50) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    check("wd.pe_cnt", pe_cnt, 1 + MAXS);
    check("wd.err", err, 1);
    check("wd.halted", halted, 1);
    check("wd.count", instr_count, 0);
    check("wd.pe_off", proc_en, 0);
    kill = 1'b0; run = 1'b0;

    // Reset in the first EXEC cycle of an add.
    mem[0] = 16'h0008; mem[1] = 16'h0080; mem[2] = 16'h0008; mem[3] = 16'h0008;
    do_reset();
    run = 1'b1;
    c = 0;
    while (pe_cnt < 4 && c < 50) begin @(negedge clk); #1; c++; end
    check("mid.pe_cnt", pe_cnt, 4);
    check("mid.count", instr_count, 1);
    check("mid.addr", mem_addr, 1);
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("mid_rst");
    din_q.delete(); pe_cnt = 0;
    @(negedge clk);
    go_free("restart");

    // Random programs in free mode.
    for (int it = 0; it < 12; it++) begin
      for (int a = 0; a < 64; a++) begin
        w = 16'($urandom);
        case ($urandom_range(0, 2))
          0:       w[8:6] = 3'b000;
          1:       w[8:6] = 3'b001;
          default: w[8:6] = 3'($urandom_range(2, 7));
        endcase
        mem[a] = w;
      end
      run_free($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the 16-bit processor core from a synchronous instruction memory. It owns the program counter and drives the memory address. It latches each instruction word (plus its immediate word for `mvi`) and presents the correct word on the processor's DIN during each execution step. It also gates the processor's step clock with a one-cycle enable per step. It sits between the on-chip program RAM and the processor and replaces manual key-clocking of both.

## Interface
- `ADDR_W`, default 6: program address width.
- `LAST_ADDR`, default 63: address of the final instruction; the sequencer halts after executing it.
- `MAX_STEPS`, default 3: maximum EXEC cycles allowed per instruction before a watchdog error.
- `Clock`  in  1: single system clock; all state changes on the rising edge.
- `Resetn`  in  1: synchronous, active-high reset.
- `Run`  in  1: start/continue request. Level-sensitive in free mode; rising edge in step mode.
- `StepMode`  in  1: 1 means execute one instruction per `Run` rising edge.
- `MemData`  in  16: RAM read data, valid one cycle after `MemAddr`.
- `Done`  in  1: processor Done, combinational for the current step.
- `MemAddr`  out  ADDR_W: RAM read address.
- `DIN`  out  16: word presented to the processor DIN.
- `ProcEn`  out  1: processor step enable; the processor advances one step on each edge where it is 1.
- `Busy`  out  1: 1 in any state other than IDLE, HALT or ERROR.
- `Halted`  out  1: sticky; 1 in HALT or ERROR.
- `Err`  out  1: sticky; watchdog expiry or `mvi` at `LAST_ADDR`.
- `InstrCount`  out  16: number of instructions completed, wraps modulo 2^16.

## Operation
- **Internal registers:** PC[ADDR_W], IW[16] (instruction word), IMM[16], step counter cnt[2], prevRun, and the state register.
- **Immediate detection:** `mvi` means the instruction word satisfies IW[8:6]==3'b001.
- **MemAddr:** always equals PC.
- **DIN selection:**
  - IW during ISSUE.
  - IMM during EXEC when the instruction is `mvi`.
  - IW during EXEC otherwise.
  - 0 in all other states.
- **IDLE:**
  - Free mode (StepMode=0): go to F_INSTR when Run=1.
  - Step mode (StepMode=1): go to F_INSTR only when Run=1 and prevRun=0.
- **F_INSTR:** go to L_INSTR.
- **L_INSTR:** IW<=MemData.
  - If MemData is `mvi` and PC==LAST_ADDR: go to ERROR.
  - If MemData is `mvi` otherwise: PC<=PC+1 and go to F_IMM.
  - Else: go to ISSUE.
- **F_IMM:** go to L_IMM.
- **L_IMM:** IMM<=MemData; go to ISSUE.
- **ISSUE:** ProcEn=1 (processor step 0 loads IR from DIN); cnt<=0; go to EXEC.
- **EXEC:** ProcEn=1.
  - If Done=1: go to ADVANCE.
  - Else if cnt==MAX_STEPS-1: go to ERROR.
  - Else: cnt<=cnt+1.
- **ADVANCE:** InstrCount<=InstrCount+1.
  - If PC==LAST_ADDR: go to HALT.
  - Otherwise PC<=PC+1, then:
    - StepMode=1 or Run=0: go to IDLE.
    - Else: go to F_INSTR.
- **HALT / ERROR:** terminal until reset. ProcEn=0. PC and InstrCount are held.
- **Run=0 mid-instruction:** ignored; the current instruction completes, then the sequencer returns to IDLE at ADVANCE.
- **StepMode change:** sampled only in IDLE and ADVANCE.

## Timing
- **Reset values:**
  - MemAddr=0, DIN=0, ProcEn=0, Busy=0, Halted=0, Err=0, InstrCount=0.
  - State=IDLE, prevRun=0.
- **Reset mid-instruction:** outputs take their reset values on the cycle after the reset edge. The processor shares `Resetn`, so its step counter clears on the same edge.
- **Latency per instruction (IDLE exit to ADVANCE exit):**
  - 2-step instruction (mv): 5 cycles.
  - mvi: 7 cycles.
  - 4-step ALU instruction (add/sub/...): 7 cycles.
- **ProcEn count per instruction:** exactly 1 (ISSUE) plus the number of EXEC cycles, always equal to the number of processor steps.
- **MemData sampling:** only in L_INSTR and L_IMM, one edge after the address was stable in the preceding state.
- **PC wrap:** never wraps; LAST_ADDR terminates execution.

## Test plan
- **mv, free mode:** mem[0]=16'h0008, LAST_ADDR=0, Run=1, Done asserted in the first EXEC cycle.
  - ProcEn high for 2 cycles; DIN=16'h0008 in both.
  - HALT after 5 cycles; InstrCount=1, Halted=1, Err=0.
- **mvi:** mem[0]=16'h0040, mem[1]=16'h00A5.
  - MemAddr sequence 0,0,1,1.
  - DIN=16'h0040 in ISSUE, 16'h00A5 in EXEC.
  - PC=2 after ADVANCE.
- **Watchdog:** Done tied 0.
  - ProcEn high for 1+MAX_STEPS=4 cycles.
  - Then Err=1, Halted=1, ProcEn stays 0; InstrCount unchanged.
- **Program end:** LAST_ADDR=3, four mv words.
  - Halted=1, InstrCount=4, MemAddr stays 3.
  - Separately, an `mvi` word at address 3 gives Err=1 with no ProcEn pulse.
- **Step mode:** StepMode=1, Run held 1.
  - Exactly one instruction executes.
  - Run 0 then 1 executes the next one; InstrCount increments by 1 per edge.
- **Reset mid-EXEC:** assert Resetn for 1 cycle in EXEC of an add.
  - Next cycle all outputs are at reset values and state is IDLE.
  - Restart fetches from address 0.
